// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte/half/word load-store unit driving a word-wide data memory port
// Define LSU_ERR_CHECK_EN to enable misalignment, range and size error detection on resp_err.
module data_mem_lsu #(
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  if (MEM_WORDS < 1) begin : g_mem_words_check
    $error("data_mem_lsu: MEM_WORDS must be at least 1");
  end

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;

  logic [1:0]  eff_size;
  logic [31:0] eff_addr;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

`ifdef LSU_ERR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  always_comb begin
    eff_size = req_size;
    eff_addr = req_addr;
    req_err  = (req_size == 2'd3)
            || (req_size == SZ_HALF && req_addr[0])
            || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            || ({1'b0, req_addr} >= ADDR_LIMIT);
  end
`else
  // Without checking, size 3 acts as word and the address is snapped to natural alignment.
  always_comb begin
    eff_size = (req_size == 2'd3) ? SZ_WORD : req_size;
    eff_addr = req_addr;
    if (eff_size == SZ_HALF) eff_addr[0] = 1'b0;
    if (eff_size == SZ_WORD) eff_addr[1:0] = 2'b00;
    req_err = 1'b0;
  end
`endif

  always_comb begin
    lane_byte = 8'h00;
    case (lane_q)
      2'd0:    lane_byte = mem_rd[7:0];
      2'd1:    lane_byte = mem_rd[15:8];
      2'd2:    lane_byte = mem_rd[23:16];
      default: lane_byte = mem_rd[31:24];
    endcase
    lane_half = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    load_data = mem_rd;
    case (size_q)
      SZ_BYTE: load_data = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = mem_rd;
    endcase
  end

  // Sub-word store: overlay the new lane(s) on the word just read back.
  always_comb begin
    merged = mem_rd;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_a      <= 32'h0;
      mem_we     <= 1'b0;
      mem_wd     <= 32'h0;
      size_q     <= 2'd0;
      lane_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            size_q     <= eff_size;
            lane_q     <= eff_addr[1:0];
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              mem_a <= {eff_addr[31:2], 2'b00};
              if (!req_we) begin
                state <= LOAD;
              end else if (eff_size == SZ_WORD) begin
                state  <= WRITE;
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_wd <= merged;
          mem_we <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu with a behavioural word memory
// Expectations follow LSU_ERR_CHECK_EN when it is defined for the build.
module tb_data_mem_lsu;

  localparam int MEM_WORDS = 2048;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
`ifdef LSU_ERR_CHECK_EN
  localparam int EXP_ERR_WE = 0;
  localparam logic [31:0] EXP_LAST_ERR = 32'd1;
`else
  localparam int EXP_ERR_WE = 1;
  localparam logic [31:0] EXP_LAST_ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        mem_init = 1'b0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          we_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_we_addr = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  data_mem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 8) ? 32'h11223344 : {16'hC0DE, 16'(i)};
  endfunction

  assign mem_rd = mem[mem_a[13:2]];
  always @(posedge clk or posedge mem_init) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_a[13:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rdata, output logic err, output int lat);
    logic [1:0]  sz;
    logic [31:0] a, w, mask;
    int          idx, sh;
    sz = size; a = addr; err = 1'b0; rdata = 32'h0; lat = 2;
`ifdef LSU_ERR_CHECK_EN
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a >= MEM_BYTES);
`else
    if (sz == 2'd3) sz = 2'd2;
    if (sz == 2'd1) a[0] = 1'b0;
    if (sz == 2'd2) a[1:0] = 2'b00;
`endif
    if (err) begin
      lat = 1;
      return;
    end
    idx = int'(a[13:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx] >> sh;
    if (!we) begin
      case (sz)
        2'd0:    rdata = uns ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        2'd1:    rdata = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        default: rdata = ref_mem[idx];
      endcase
    end else if (sz == 2'd2) begin
      ref_mem[idx] = wd;
    end else begin
      mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
      lat = 3;
    end
  endfunction

  task automatic garbage();
    req_valid = 1'b1;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit keep);
    exp_t e;
    int   budget = 100;
    while (req_ready !== 1'b1 && budget > 0) begin
      if (keep) garbage(); else req_valid = 1'b0;
      @(negedge clk);
      budget--;
    end
    chk("send_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    model(we, sz, uns, a, wd, e.rdata, e.err, e.lat);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_ready_low", 32'(req_ready), 32'd0);
    if (keep) garbage(); else req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready === 1'b1) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        we_cnt++;
        last_we_addr = mem_a;
      end
      if (resp_valid) begin
        resp_cnt++;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        chk("resp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", 32'(resp_err), 32'(mon_e.err));
          chk("resp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1 mem_init = 1'b1;
    #1 mem_init = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    w0 = we_cnt;
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0); wait_idle();
    chk("wstore_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wstore_we_addr", last_we_addr, 32'h10);
    chk("wstore_mem", mem[4], 32'hDEADBEEF);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    chk("wload_value", last_rdata, 32'hDEADBEEF);

    send(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 1'b0); wait_idle();
    chk("bstore_mem", mem[8], 32'h11AA3344);
    send(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1'b0); wait_idle();
    chk("bload_signed", last_rdata, 32'hFFFFFFAA);
    send(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 1'b0); wait_idle();
    chk("bload_unsigned", last_rdata, 32'h000000AA);

    send(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b0); wait_idle();
    chk("hstore_mem", mem[8], 32'h80013344);
    send(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0); wait_idle();
    chk("hload_signed", last_rdata, 32'hFFFF8001);
    send(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0); wait_idle();
    chk("hload_unsigned", last_rdata, 32'h00003344);

    w0 = we_cnt;
    send(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b0); wait_idle();
    send(1'b1, 2'd1, 1'b0, 32'h21, 32'h00005555, 1'b0); wait_idle();
    chk("err_half_mem", mem[8], ref_mem[8]);
    send(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1'b0); wait_idle();
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    chk("err_we_pulses", 32'(we_cnt - w0), 32'(EXP_ERR_WE));
    chk("err_last_flag", 32'(last_err), EXP_LAST_ERR);

    r0 = resp_cnt;
    send(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, 1'b1);
    send(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 1'b1);
    send(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 1'b1);
    send(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    chk("stream_resp_count", 32'(resp_cnt - r0), 32'd4);
    chk("stream_mem", mem[12], 32'hBEEF5678);

    w0 = we_cnt; r0 = resp_cnt;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_we_pulses", 32'(we_cnt - w0), 32'd0);
    chk("abort_resp_count", 32'(resp_cnt - r0), 32'd0);
    chk("abort_mem", mem[16], init_word(16));
    send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0); wait_idle();
    chk("abort_reload", last_rdata, init_word(16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store unit that initiates accesses on the data memory's word port: word address, write enable, write data, combinational read data, write on posedge.
Takes CPU byte, halfword and word load/store requests over a valid/ready handshake and returns one response per request.
Sub-word stores are done as read-modify-write, because the memory writes only whole words.
Sits between the CPU datapath and data_memory.

Parameters:
MEM_WORDS, 2048, number of 32-bit words in the attached data memory; byte addresses >= MEM_WORDS*4 are out of range.

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and treated as an error
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; misaligned, out of range, or size 3
mem_a  output  32  word-aligned byte address to memory: {addr[31:2],2'b00}
mem_we  output  1  memory write enable
mem_wd  output  32  memory write data
mem_rd  input  32  memory combinational read data

Behaviour:
- Reset (async): state = IDLE. req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
- Accept when req_valid && req_ready. Latch addr, size, we, unsigned and wdata into registers.
- While busy, ignore all req_* inputs.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE -> RESP on error. Error means:
  - size 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_WORDS*4.
  No memory access is made on the error path.
- IDLE -> LOAD for a load. LOAD drives mem_a, captures mem_rd, extracts the lane and extends it, then -> RESP.
  - Load latency: resp_valid 2 cycles after the accept edge.
- IDLE -> WRITE for a word store. WRITE drives mem_we = 1 and mem_wd = wdata for exactly one cycle, then -> RESP.
- IDLE -> RMW_RD for a byte or half store.
  - RMW_RD captures mem_rd and merges wdata into the addressed lane(s), keeping the other bytes.
  - -> WRITE, which writes the merged word.
  - Sub-word store latency: 3 cycles.
- Byte lanes are little-endian:
  - byte n occupies bits [8n+7:8n], with n = addr[1:0];
  - half at addr[1] = 1 occupies bits [31:16].
- RESP: resp_valid = 1 for one cycle, then -> IDLE.
  - req_ready returns high in the cycle after RESP.
  - Maximum throughput is one request per 3 (load) or 4 (sub-word store) cycles.
- mem_we is high only in WRITE. mem_a is held stable from LOAD/RMW_RD through WRITE.
- resp_rdata and resp_err are held until the next response. resp_rdata = 0 on stores and on errors.
- Reset mid-operation aborts the access immediately. mem_we drops asynchronously, no response is produced, and the pending request is lost.

Optional Feature:
- Macro: LSU_ERR_CHECK_EN.
- Defined: error detection and resp_err as described above.
- Undefined:
  - resp_err is tied to 0;
  - misalignment is ignored: the low address bits are forced to the natural alignment for the size (half: addr[0] = 0; word: addr[1:0] = 0);
  - out-of-range addresses are passed through unchanged;
  - size 3 is treated as word.

Test Plan:
- Reset, then word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> mem_we pulses for 1 cycle with mem_a = 0x10; load resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 2 cycles after accept.
- Memory word at 0x20 = 0x11223344; byte store 0xAA to 0x22 -> memory becomes 0x11AA3344. Then signed byte load from 0x22 -> 0xFFFFFFAA; unsigned byte load -> 0x000000AA.
- Half store 0x8001 to 0x22 over 0x11AA3344 -> 0x80013344. Signed half load from 0x22 -> 0xFFFF8001; unsigned half load from 0x20 -> 0x00003344.
- Error checks, each producing resp_valid the cycle after accept, resp_err = 1, no mem_we pulse (LSU_ERR_CHECK_EN defined), and memory contents unchanged:
  - word load at 0x13;
  - half store at 0x21;
  - word load at 0x2000 with MEM_WORDS = 2048;
  - size 3.
- Hold req_valid high continuously -> req_ready is low while busy; exactly one response per accepted request; inputs changed mid-operation do not affect the result.
- Assert reset during RMW_RD of a byte store -> no mem_we pulse, no resp_valid, memory unchanged; after release, req_ready = 1 and the next load returns the original word.
